// File: rtl/sel_mux_rr.sv
// ============================================================================
// Module      : sel_mux_rr
// Description : N-input registered selector with fixed-select or round-robin
//               arbitration feeding a one-entry valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sel_mux_rr #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [SEL_W-1:0]  r_ptr;
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_sel;
    logic              r_out_valid;

    logic [NUM_IN-1:0] w_rot;
    logic [SEL_W:0]    w_sum;
    logic [SEL_W-1:0]  w_gidx;
    logic              w_gvld;
    logic [SEL_W-1:0]  w_ptr_nxt;
    logic [WIDTH-1:0]  w_data;
    logic              w_can_load;
    logic              w_load;

    // Rotate valids so bit j is input (ptr+j) mod NUM_IN; lowest set bit wins.
    always_comb begin
        w_rot  = NUM_IN'({in_valid, in_valid} >> r_ptr);
        w_sum  = '0;
        w_gidx = '0;
        w_gvld = 1'b0;
        if (mode) begin
            for (int j = NUM_IN - 1; j >= 0; j--) begin
                if (w_rot[j]) begin
                    w_sum  = {1'b0, r_ptr} + (SEL_W+1)'(j);
                    w_gvld = 1'b1;
                end
            end
            if (w_sum >= (SEL_W+1)'(NUM_IN)) begin
                w_sum = w_sum - (SEL_W+1)'(NUM_IN);
            end
            w_gidx = w_sum[SEL_W-1:0];
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if ((sel == SEL_W'(i)) && in_valid[i]) begin
                    w_gidx = sel;
                    w_gvld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_can_load = !r_out_valid || out_ready;
        w_load     = w_gvld && w_can_load;
        w_data     = '0;
        in_ready   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_gidx == SEL_W'(i)) begin
                w_data      = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = w_load;
            end
        end
        w_ptr_nxt = (w_gidx == SEL_W'(NUM_IN - 1)) ? '0 : w_gidx + SEL_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_data;
            r_out_sel   <= w_gidx;
            r_out_valid <= 1'b1;
            if (mode) begin
                r_ptr <= w_ptr_nxt;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: doc/sel_mux_rr.md
# sel_mux_rr

Parametrised N-input, WIDTH-bit registered selector: the pipelined successor of the datapath 2:1 muxes. Each cycle it picks one valid input, either by an explicit select index (fixed mode) or by round-robin arbitration, and hands the word to a one-entry output register with a valid/ready handshake. It sits wherever several producers (register-file write sources, ALU operand sources, memory-port requesters) share one consumer that may stall.

## Interface
- WIDTH, 32: data width in bits (1..64).
- NUM_IN, 4: number of inputs (2..16).
- SEL_W, $clog2(NUM_IN): select/index width; derived, never overridden.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = fixed select via sel, 1 = round-robin.
- sel  in  SEL_W  input index used in fixed mode.
- in_data  in  NUM_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-input valid.
- in_ready  out  NUM_IN  per-input ready; combinational; at most one bit high.
- out_data  out  WIDTH  registered selected word.
- out_sel  out  SEL_W  index of the input that supplied out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word this cycle.

## Operation
- Handshake: a transfer on input i occurs when in_valid[i] && in_ready[i]; on output when out_valid && out_ready.
- can_load = !out_valid || out_ready. in_ready[i] = grant[i] && can_load.
- Fixed mode (mode=0): grant[sel] = in_valid[sel] when sel < NUM_IN; otherwise no grant. Other inputs see in_ready=0 even if valid.
- Round-robin mode (mode=1): priority pointer ptr (SEL_W bits). Grant goes to the first valid input found searching ptr, ptr+1, ... wrapping modulo NUM_IN. No valid input → no grant.
- Pointer update: only on an input transfer in round-robin mode; ptr <= (granted index + 1) mod NUM_IN, with NUM_IN-1 wrapping to 0. Pointer holds in fixed mode and when no transfer occurs.
- On an input transfer: out_data <= selected word, out_sel <= granted index, out_valid <= 1.
- Output consumed with no new input transfer: out_valid <= 0; out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready): out_data, out_sel and out_valid hold; all in_ready = 0.
- mode and sel are sampled combinationally each cycle; a change affects the grant in the same cycle and never corrupts a word already in the output register.
- Inputs are never dropped or duplicated: every input transfer produces exactly one output transfer, in order.

## Timing
- Reset (reset_n low, asynchronous): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is therefore all-zero during reset only when no input is valid; the consumer must ignore in_ready while reset_n is low. The first input transfer can occur on the first rising edge after reset_n deasserts.
- Latency: an input transfer at edge k makes the word visible on out_data with out_valid=1 after edge k.
- Throughput: one word per cycle while out_ready=1 and some granted input is valid (simultaneous output consume and input load in the same cycle).
- Reset asserted mid-stall: the held word is discarded and the pointer returns to 0.
- Fairness: in round-robin mode, with all inputs continuously valid and out_ready=1, each input is served exactly once every NUM_IN cycles.

## Test plan
- Reset: hold reset_n=0 with inputs valid → out_valid=0, out_data=0, out_sel=0. Release reset_n, NUM_IN=4, mode=1, all valid, out_ready=1 → out_sel sequence is 0,1,2,3,0 on consecutive cycles.
- Fixed mode: mode=0, sel=2, in_valid=4'b1111, in_data[2]=32'hDEADBEEF → in_ready=4'b0100; the next cycle gives out_data=32'hDEADBEEF and out_sel=2. With sel=2 and in_valid=4'b1011 → in_ready=0 and no load.
- Round-robin skip and wrap: mode=1, ptr=3, in_valid=4'b0101 → input 0 is granted, then ptr=1; on the next cycle input 2 is granted, then ptr=3.
- Stall: load 32'h12345678, hold out_ready=0 for 5 cycles with inputs valid → out_data stable, in_ready=0, ptr unchanged; raise out_ready → the word is consumed and the next word loads in the same cycle.
- Bubble: a single valid word is consumed and no input is valid → out_valid=0 on the next cycle and out_data holds its last value.
- Random soak: random in_valid, out_ready, mode and sel over 10k cycles, checked against a scoreboard → no loss, no duplication, order preserved, at most one in_ready bit high, and round-robin fairness holds under full load.
